// File: rtl/spi_frame_pkg.sv
// Shared definitions for the SPI frame controller.
//   - FSM state encoding (IDLE/SETUP/SHIFT/HOLD)
//   - Frame geometry: 16-bit frame = {rw, addr[6:0], data[7:0]}, MSB first
//   - pack_frame(): assembles the frame word from its fields
package spi_frame_pkg;

  localparam int FRAME_BITS = 16;
  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 8;
  localparam int RW_BIT     = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  function automatic logic [FRAME_BITS-1:0] pack_frame(
    input logic              rw,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] data
  );
    logic [FRAME_BITS-1:0] f;
    f                     = '0;
    f[RW_BIT]             = rw;
    f[RW_BIT-1 -: ADDR_W] = addr;
    f[DATA_W-1:0]         = data;
    return f;
  endfunction

endpackage

// File: rtl/spi_frame_controller_if.sv
// Bundle of the frame request handshake and the SPI pins.
//   master modport: the controller (takes requests, drives SCLK/COPI/nCS)
//   slave modport : the requester / SPI peripheral side
//   start/rw/addr/wdata : frame request, sampled when start is accepted
//   busy/done/rdata     : frame status and captured read data
//   sclk/copi/ncs/cipo  : SPI mode-0 pins
interface spi_frame_controller_if;
  import spi_frame_pkg::*;

  logic              start;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rdata;
  logic              sclk;
  logic              copi;
  logic              cipo;
  logic              ncs;

  modport master (
    input  start, rw, addr, wdata, cipo,
    output busy, done, rdata, sclk, copi, ncs
  );

  modport slave (
    output start, rw, addr, wdata, cipo,
    input  busy, done, rdata, sclk, copi, ncs
  );
endinterface

// File: rtl/spi_half_tick.sv
// SCLK half-period timer: 8-bit loadable down-counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : force reload to CLK_DIV-1
//   tick       : high for the one cycle the count sits at zero; the counter
//                then reloads to CLK_DIV-1, so ticks repeat every CLK_DIV cycles
module spi_half_tick #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic tick
);
  localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

  logic [7:0] cnt;

  assign tick = (cnt == 8'd0);

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 8'd0;
    end else if (load || tick) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - 8'd1;
    end
  end
endmodule

// File: rtl/spi_frame_controller.sv
// SPI mode-0 frame controller: shifts one 16-bit {rw, addr, wdata} frame out
// on COPI, MSB first, and captures CIPO during the 8 data bits into rdata.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : spi_frame_controller_if.master (request, status, SPI pins)
//   CLK_DIV    : SCLK half-period H in clk cycles (1..255)
// A frame accepted at cycle T drops nCS at T+1 and pulses done at T+1+33H.
module spi_frame_controller
  import spi_frame_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input logic                    clk,
  input logic                    rst_n,
  spi_frame_controller_if.master bus
);
  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] SETUP = ST_SETUP;
  localparam logic [1:0] SHIFT = ST_SHIFT;
  localparam logic [1:0] HOLD  = ST_HOLD;

  logic [1:0]            state;
  logic [FRAME_BITS-1:0] shreg;
  logic [DATA_W-1:0]     cap;
  logic [DATA_W-1:0]     rdata_q;
  logic [4:0]            bit_cnt;   // rising edges issued so far, 0..16
  logic                  sclk_q;
  logic                  done_q;
  logic                  load;
  logic                  tick;

  // Every state change after the accept and every SCLK edge happens on a
  // tick, and the timer reloads itself on a tick; only the accept needs an
  // explicit load.
  assign load = (state == IDLE) && bus.start;

  spi_half_tick #(.CLK_DIV(CLK_DIV)) u_half_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shreg   <= '0;
      cap     <= '0;
      rdata_q <= '0;
      bit_cnt <= '0;
      sclk_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            shreg   <= pack_frame(bus.rw, bus.addr, bus.wdata);
            bit_cnt <= '0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          // Rising edge 0 carries the rw bit; nothing to capture yet.
          if (tick) begin
            sclk_q  <= 1'b1;
            bit_cnt <= bit_cnt + 5'd1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (tick) begin
            if (!sclk_q) begin
              sclk_q  <= 1'b1;
              bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt >= 5'(DATA_W)) cap <= {cap[DATA_W-2:0], bus.cipo};
            end else begin
              sclk_q <= 1'b0;
              // The 16th fall leaves COPI on bit 0 through HOLD.
              if (bit_cnt == 5'(FRAME_BITS)) state <= HOLD;
              else shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
            end
          end
        end
        HOLD: begin
          if (tick) begin
            done_q  <= 1'b1;
            rdata_q <= cap;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pin levels are decoded from the state register so an asynchronous reset
  // releases nCS and COPI at once, without waiting for a clock edge.
  assign bus.ncs   = (state == IDLE);
  assign bus.busy  = (state != IDLE);
  assign bus.copi  = (state != IDLE) && shreg[FRAME_BITS-1];
  assign bus.sclk  = sclk_q;
  assign bus.done  = done_q;
  assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_spi_frame_controller.sv
// Self-checking bench: DUT A runs with CLK_DIV=2, DUT B with CLK_DIV=1.
// A peripheral model per DUT records COPI at each SCLK rise, drives CIPO on
// the low phase, and measures nCS/SCLK/done timing against the frame rules.
module tb_spi_frame_controller;
  localparam int H_A = 2;
  localparam int H_B = 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_frame_controller_if a_if ();
  spi_frame_controller_if b_if ();

  spi_frame_controller #(.CLK_DIV(H_A)) u_a (.clk(clk), .rst_n(rst_n), .bus(a_if.master));
  spi_frame_controller #(.CLK_DIV(H_B)) u_b (.clk(clk), .rst_n(rst_n), .bus(b_if.master));

  // Stimulus and observation, index 0 = DUT A, 1 = DUT B
  logic [1:0]      start_d = '0, rw_d = '0, cipo_d = '0;
  logic [1:0][6:0] addr_d  = '0;
  logic [1:0][7:0] wdata_d = '0, pat = '0;
  logic [1:0]      ncs_o, sclk_o, copi_o, busy_o, done_o;
  logic [1:0][7:0] rdata_o;

  assign a_if.start = start_d[0];  assign b_if.start = start_d[1];
  assign a_if.rw    = rw_d[0];     assign b_if.rw    = rw_d[1];
  assign a_if.addr  = addr_d[0];   assign b_if.addr  = addr_d[1];
  assign a_if.wdata = wdata_d[0];  assign b_if.wdata = wdata_d[1];
  assign a_if.cipo  = cipo_d[0];   assign b_if.cipo  = cipo_d[1];
  assign ncs_o   = {b_if.ncs,   a_if.ncs};
  assign sclk_o  = {b_if.sclk,  a_if.sclk};
  assign copi_o  = {b_if.copi,  a_if.copi};
  assign busy_o  = {b_if.busy,  a_if.busy};
  assign done_o  = {b_if.done,  a_if.done};
  assign rdata_o = {b_if.rdata, a_if.rdata};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Peripheral model / monitor state
  logic [1:0]       prev_ncs = 2'b11, prev_sclk = 2'b00, prev_copi = 2'b00;
  logic [1:0][15:0] copi_cap = '0;
  logic [1:0][7:0]  rdata_at_done = '0;
  logic [1:0]       busy_at_done = '0;
  int rise_cnt [2] = '{0, 0};
  int last_rise [2] = '{0, 0};
  int fall_time [2] = '{0, 0};
  int done_time [2] = '{0, 0};
  int done_cnt [2] = '{0, 0};
  int ncs_low_run [2] = '{0, 0};
  int ncs_low_last [2] = '{0, 0};
  int ncs_high_run [2] = '{0, 0};
  int ncs_high_last [2] = '{0, 0};
  int timing_bad [2] = '{0, 0};
  int copi_unstable [2] = '{0, 0};

  always @(negedge clk) begin
    int h, gap, idx;
    for (int i = 0; i < 2; i++) begin
      h = (i == 0) ? H_A : H_B;
      if (!ncs_o[i] && prev_ncs[i]) begin
        fall_time[i]     = cyc;
        ncs_low_run[i]   = 1;
        ncs_high_last[i] = ncs_high_run[i];
        rise_cnt[i]      = 0;
        copi_cap[i]      = '0;
      end else if (!ncs_o[i]) begin
        ncs_low_run[i]++;
      end else if (!prev_ncs[i]) begin
        ncs_low_last[i] = ncs_low_run[i];
        ncs_high_run[i] = 1;
      end else begin
        ncs_high_run[i]++;
      end
      if (ncs_o[i] && sclk_o[i]) timing_bad[i]++;
      if (sclk_o[i] && !prev_sclk[i]) begin
        // first rise comes H after nCS falls, later rises every 2H
        gap = (rise_cnt[i] == 0) ? cyc - fall_time[i] : cyc - last_rise[i];
        if (gap != ((rise_cnt[i] == 0) ? h : 2 * h)) timing_bad[i]++;
        last_rise[i] = cyc;
        copi_cap[i]  = {copi_cap[i][14:0], copi_o[i]};
        rise_cnt[i]++;
      end else if (sclk_o[i] && prev_sclk[i] && (copi_o[i] != prev_copi[i])) begin
        copi_unstable[i]++;
      end
      if (done_o[i]) begin
        done_cnt[i]++;
        done_time[i]     = cyc;
        busy_at_done[i]  = busy_o[i];
        rdata_at_done[i] = rdata_o[i];
      end
      // Peripheral answers data bits 7..0 on rises 8..15, changing only while SCLK is low
      if (!sclk_o[i]) begin
        idx = 15 - rise_cnt[i];
        cipo_d[i] = (rise_cnt[i] >= 8 && rise_cnt[i] < 16) ? pat[i][idx[2:0]] : 1'b0;
      end
      prev_ncs[i]  = ncs_o[i];
      prev_sclk[i] = sclk_o[i];
      prev_copi[i] = copi_o[i];
    end
  end

  // Reference model: expected frame word, read data and timing per DUT
  int checks = 0, errors = 0;
  logic [1:0][15:0] exp_frame = '0;
  logic [1:0][7:0]  exp_pat = '0, exp_rdata = '0;
  int t_acc [2] = '{0, 0};
  int done_base [2] = '{0, 0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic string pfx(input int i);
    return (i == 0) ? "A" : "B";
  endfunction

  // Called mid-cycle; the next rising edge is the accept edge (cycle T = cyc).
  task automatic start_frame(input int i, input logic r, input logic [6:0] a,
                             input logic [7:0] d, input logic [7:0] p);
    t_acc[i]     = cyc;
    done_base[i] = done_cnt[i];
    exp_frame[i] = {r, a, d};
    exp_pat[i]   = p;
    pat[i]       = p;
    rw_d[i]      = r;
    addr_d[i]    = a;
    wdata_d[i]   = d;
    start_d[i]   = 1'b1;
    step();
    start_d[i]   = 1'b0;
  endtask

  task automatic wait_done(input int i, input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt[i] < target && n < budget) begin
      step();
      n++;
    end
    check({pfx(i), ".done_seen"}, 32'(done_cnt[i] >= target), 32'd1);
  endtask

  task automatic finish_frame(input int i);
    int h;
    h = (i == 0) ? H_A : H_B;
    wait_done(i, done_base[i] + 1, 40 * h + 20);
    check({pfx(i), ".ncs_fall_latency"}, 32'(fall_time[i] - t_acc[i]), 32'd1);
    check({pfx(i), ".done_latency"}, 32'(done_time[i] - t_acc[i]), 32'(1 + 33 * h));
    check({pfx(i), ".ncs_low_cycles"}, 32'(ncs_low_last[i]), 32'(33 * h));
    check({pfx(i), ".copi_bits"}, 32'(copi_cap[i]), 32'(exp_frame[i]));
    check({pfx(i), ".rise_count"}, 32'(rise_cnt[i]), 32'd16);
    check({pfx(i), ".rdata_at_done"}, 32'(rdata_at_done[i]), 32'(exp_pat[i]));
    check({pfx(i), ".busy_in_done"}, 32'(busy_at_done[i]), 32'd0);
    check({pfx(i), ".sclk_timing_errs"}, 32'(timing_bad[i]), 32'd0);
    check({pfx(i), ".copi_stability_errs"}, 32'(copi_unstable[i]), 32'd0);
    exp_rdata[i] = exp_pat[i];
  endtask

  task automatic run_frame(input int i, input logic r, input logic [6:0] a,
                           input logic [7:0] d, input logic [7:0] p);
    step();
    start_frame(i, r, a, d, p);
    repeat (3) step();
    check({pfx(i), ".rdata_hold"}, 32'(rdata_o[i]), 32'(exp_rdata[i]));
    finish_frame(i);
  endtask

  task automatic run_random(input int i);
    run_frame(i, 1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom), 8'($urandom));
  endtask

  initial begin
    int base;
    rst_n = 1'b0;
    repeat (5) step();
    for (int i = 0; i < 2; i++) begin
      check({pfx(i), ".rst_ncs"},   32'(ncs_o[i]),   32'd1);
      check({pfx(i), ".rst_sclk"},  32'(sclk_o[i]),  32'd0);
      check({pfx(i), ".rst_copi"},  32'(copi_o[i]),  32'd0);
      check({pfx(i), ".rst_busy"},  32'(busy_o[i]),  32'd0);
      check({pfx(i), ".rst_done"},  32'(done_o[i]),  32'd0);
      check({pfx(i), ".rst_rdata"}, 32'(rdata_o[i]), 32'd0);
    end
    rst_n = 1'b1;
    step();

    // Write frame 0x80F0 with the peripheral returning 0xA5
    run_frame(0, 1'b1, 7'h00, 8'hF0, 8'hA5);
    // Read frame: rdata must still read 0xA5 until this frame's done
    run_frame(0, 1'b0, 7'h5A, 8'h3C, 8'h69);

    // start while busy is ignored
    step();
    start_frame(0, 1'b1, 7'h12, 8'h34, 8'hC3);
    repeat (9) step();
    start_d[0] = 1'b1; rw_d[0] = 1'b0; addr_d[0] = 7'h7F; wdata_d[0] = 8'h00;
    step();
    start_d[0] = 1'b0;
    finish_frame(0);
    repeat (80) step();
    check("A.single_done", 32'(done_cnt[0]), 32'(done_base[0] + 1));
    check("A.idle_after_ignored_start", 32'(ncs_o[0]), 32'd1);

    // Back-to-back: second start issued in the done cycle
    step();
    start_frame(0, 1'b0, 7'h2B, 8'h81, 8'h1E);
    finish_frame(0);
    start_frame(0, 1'b1, 7'h44, 8'hE7, 8'hB2);
    check("A.b2b_ncs_high_cycles", 32'(ncs_high_last[0]), 32'd1);
    finish_frame(0);

    repeat (4) run_random(0);

    // Abort mid-frame while SCLK is high (rise 7 at T+31)
    step();
    start_frame(0, 1'b1, 7'h33, 8'h55, 8'hAA);
    repeat (30) step();
    check("A.sclk_before_abort", 32'(sclk_o[0]), 32'd1);
    base = done_cnt[0];
    rst_n = 1'b0;
    #1;
    check("A.abort_ncs",  32'(ncs_o[0]),  32'd1);
    check("A.abort_sclk", 32'(sclk_o[0]), 32'd0);
    check("A.abort_busy", 32'(busy_o[0]), 32'd0);
    check("A.abort_copi", 32'(copi_o[0]), 32'd0);
    exp_rdata = '0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (80) step();
    check("A.no_done_after_abort", 32'(done_cnt[0]), 32'(base));
    check("A.rdata_after_abort", 32'(rdata_o[0]), 32'd0);
    run_frame(0, 1'b0, 7'h61, 8'h9D, 8'h4F);

    // CLK_DIV = 1
    run_frame(1, 1'b1, 7'h00, 8'hF0, 8'hA5);
    repeat (3) run_random(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
